// File: rtl/spm_banked_pkg.sv
// Shared constants for the banked scratch pad memory: strobe/direction
// encodings and helpers that derive field widths from the block parameters.
package spm_banked_pkg;

    // Address strobe is active low; rw selects read (1) or write (0).
    localparam logic SPM_ENABLE_  = 1'b0;
    localparam logic SPM_DISABLE_ = 1'b1;
    localparam logic SPM_READ     = 1'b1;
    localparam logic SPM_WRITE    = 1'b0;

    // Width of a field that may legally be zero bits wide; keeps at least 1.
    function automatic int field_w(input int n);
        return (n > 0) ? n : 1;
    endfunction

    // Width of the starvation counter able to hold 0..max.
    function automatic int cnt_w(input int max);
        return (max > 0) ? $clog2(max + 1) : 1;
    endfunction

endpackage

// File: rtl/spm_banked_if.sv
// Request/response bundle for one SPM port (IF or MEM stage).
// Byte-lane enables exist only when SPM_BYTE_WRITE_EN is defined.
//
// Handshake: a request is active while as_ is low. It is accepted in any
// cycle where it is active and busy is low; busy is combinational from the
// current request, so the requester must hold addr/rw/wr_data/be stable while
// busy is high. A read returns rd_data with a one-cycle rd_valid pulse in the
// cycle after acceptance; rd_data then holds until the next accepted read.
interface spm_banked_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 30
);
    logic [ADDR_W-1:0]   addr;
    logic                as_;
    logic                rw;
    logic [DATA_W-1:0]   wr_data;
`ifdef SPM_BYTE_WRITE_EN
    logic [DATA_W/8-1:0] be;
`endif
    logic                busy;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_valid;

`ifdef SPM_BYTE_WRITE_EN
    modport master (output addr, as_, rw, wr_data, be, input busy, rd_data, rd_valid);
    modport slave  (input addr, as_, rw, wr_data, be, output busy, rd_data, rd_valid);
`else
    modport master (output addr, as_, rw, wr_data, input busy, rd_data, rd_valid);
    modport slave  (input addr, as_, rw, wr_data, output busy, rd_data, rd_valid);
`endif

endinterface

// File: rtl/spm_banked_bank.sv
// One single-port SPM bank: synchronous write, registered read.
// With SPM_BYTE_WRITE_EN defined, writes update only the enabled byte lanes.
module spm_banked_bank #(
    parameter int DATA_W = 32,
    parameter int ROW_W  = 11
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [ROW_W-1:0]    row,
    input  logic [DATA_W-1:0]   wr_data,
`ifdef SPM_BYTE_WRITE_EN
    input  logic [DATA_W/8-1:0] be,
`endif
    output logic [DATA_W-1:0]   rd_data
);

    logic [DATA_W-1:0] mem [2**ROW_W];

    // Storage access: write commits or read is captured on the enabled edge.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
`ifdef SPM_BYTE_WRITE_EN
                for (int i = 0; i < DATA_W / 8; i++) begin
                    if (be[i]) begin
                        mem[row][8*i +: 8] <= wr_data[8*i +: 8];
                    end
                end
`else
                mem[row] <= wr_data;
`endif
            end else begin
                rd_data <= mem[row];
            end
        end
    end

endmodule

// File: rtl/spm_banked.sv
// Dual-port (IF/MEM) scratch pad built from 2**BANKS_LOG2 word-interleaved
// single-port banks. Same-bank requests are serialised with MEM priority,
// overridden for IF after STARVE_MAX consecutive IF stall cycles.
// Optional feature macro: SPM_BYTE_WRITE_EN (byte-lane write enables).
module spm_banked
    import spm_banked_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 30,
    parameter int DEPTH_LOG2 = 12,
    parameter int BANKS_LOG2 = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                           clk,
    input  logic                           reset_,
    spm_banked_if.slave                    if_spm,
    spm_banked_if.slave                    mem_spm,
    output logic [cnt_w(STARVE_MAX)-1:0]   dbg_stall_cnt,
    output logic                           dbg_pri_if
);

    localparam int NB     = 1 << BANKS_LOG2;
    localparam int BANK_W = field_w(BANKS_LOG2);
    localparam int ROW_W  = DEPTH_LOG2 - BANKS_LOG2;
    localparam int CNT_W  = cnt_w(STARVE_MAX);
    localparam logic [BANK_W-1:0] BANK_MASK = BANK_W'(NB - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT   = '1;
    localparam logic [CNT_W-1:0]  CNT_TGT   = CNT_W'(STARVE_MAX);

    logic              if_act, mem_act, conflict;
    logic              if_busy, mem_busy, if_acc, mem_acc;
    logic [BANK_W-1:0] if_bank, mem_bank;
    logic [ROW_W-1:0]  if_row, mem_row;

    logic [CNT_W-1:0]  stall_cnt, stall_cnt_n;
    logic              pri_if, pri_if_n;

    logic [DATA_W-1:0] bank_q [NB];

    logic              if_rd_valid_q, mem_rd_valid_q;
    logic [BANK_W-1:0] if_rd_bank_q, mem_rd_bank_q;
    logic [DATA_W-1:0] if_hold_q, mem_hold_q;
    logic [DATA_W-1:0] if_rd_data_w, mem_rd_data_w;

    // Address bits at DEPTH_LOG2 and above alias and are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_spm.addr[ADDR_W-1:DEPTH_LOG2],
                                mem_spm.addr[ADDR_W-1:DEPTH_LOG2]};

    assign if_act   = (if_spm.as_ == SPM_ENABLE_);
    assign mem_act  = (mem_spm.as_ == SPM_ENABLE_);
    assign if_bank  = if_spm.addr[BANK_W-1:0] & BANK_MASK;
    assign mem_bank = mem_spm.addr[BANK_W-1:0] & BANK_MASK;
    assign if_row   = if_spm.addr[BANKS_LOG2 +: ROW_W];
    assign mem_row  = mem_spm.addr[BANKS_LOG2 +: ROW_W];

    // Arbitration is purely combinational so busy answers in the request cycle.
    assign conflict = if_act && mem_act && (if_bank == mem_bank);
    assign if_busy  = conflict && !pri_if;
    assign mem_busy = conflict && pri_if;
    assign if_acc   = if_act && !if_busy;
    assign mem_acc  = mem_act && !mem_busy;

    // Route each accepted request to its bank; conflicts never reach here.
    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic if_hit, mem_hit;
        assign if_hit  = if_acc && (if_bank == BANK_W'(b));
        assign mem_hit = mem_acc && (mem_bank == BANK_W'(b));

        spm_banked_bank #(
            .DATA_W (DATA_W),
            .ROW_W  (ROW_W)
        ) u_bank (
            .clk     (clk),
            .en      (if_hit || mem_hit),
            .we      (if_hit ? (if_spm.rw == SPM_WRITE) : (mem_spm.rw == SPM_WRITE)),
            .row     (if_hit ? if_row : mem_row),
            .wr_data (if_hit ? if_spm.wr_data : mem_spm.wr_data),
`ifdef SPM_BYTE_WRITE_EN
            .be      (if_hit ? if_spm.be : mem_spm.be),
`endif
            .rd_data (bank_q[b])
        );
    end

    // Starvation state register: counter and IF-priority flag.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            stall_cnt <= '0;
            pri_if    <= 1'b0;
        end else begin
            stall_cnt <= stall_cnt_n;
            pri_if    <= pri_if_n;
        end
    end

    // Starvation next state: count IF stalls, grant IF priority at the limit.
    always_comb begin
        stall_cnt_n = stall_cnt;
        pri_if_n    = pri_if;
        if (if_acc) begin
            stall_cnt_n = '0;
            pri_if_n    = 1'b0;
        end else if (if_busy) begin
            if (stall_cnt != CNT_SAT) begin
                stall_cnt_n = stall_cnt + 1'b1;
            end
            if ((STARVE_MAX != 0) && (stall_cnt_n >= CNT_TGT)) begin
                pri_if_n = 1'b1;
            end
        end
    end

    // Per-port read tracking: valid pulse, source bank, and held read data.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            if_rd_valid_q  <= 1'b0;
            mem_rd_valid_q <= 1'b0;
            if_rd_bank_q   <= '0;
            mem_rd_bank_q  <= '0;
            if_hold_q      <= '0;
            mem_hold_q     <= '0;
        end else begin
            if_rd_valid_q  <= if_acc && (if_spm.rw == SPM_READ);
            mem_rd_valid_q <= mem_acc && (mem_spm.rw == SPM_READ);
            if (if_acc) if_rd_bank_q <= if_bank;
            if (mem_acc) mem_rd_bank_q <= mem_bank;
            if_hold_q      <= if_rd_data_w;
            mem_hold_q     <= mem_rd_data_w;
        end
    end

    // Outputs: fresh bank data during the valid cycle, otherwise the held copy
    // (bank registers may be overwritten by the other port afterwards).
    always_comb begin
        if_rd_data_w  = if_rd_valid_q ? bank_q[if_rd_bank_q] : if_hold_q;
        mem_rd_data_w = mem_rd_valid_q ? bank_q[mem_rd_bank_q] : mem_hold_q;
    end

    assign if_spm.busy      = if_busy;
    assign if_spm.rd_data   = if_rd_data_w;
    assign if_spm.rd_valid  = if_rd_valid_q;
    assign mem_spm.busy     = mem_busy;
    assign mem_spm.rd_data  = mem_rd_data_w;
    assign mem_spm.rd_valid = mem_rd_valid_q;
    assign dbg_stall_cnt    = stall_cnt;
    assign dbg_pri_if       = pri_if;

endmodule

// File: tb/tb_spm_banked.sv
// Directed bench for spm_banked (BANKS_LOG2 = 1, STARVE_MAX = 2).
// Works with SPM_BYTE_WRITE_EN defined or undefined.
module tb_spm_banked;

    logic       clk;
    logic       reset_;
    logic [1:0] dbg_stall_cnt;
    logic       dbg_pri_if;

    int compared;
    int mismatched;

    spm_banked_if #(.DATA_W(32), .ADDR_W(30)) if_bus ();
    spm_banked_if #(.DATA_W(32), .ADDR_W(30)) mem_bus ();

    spm_banked #(
        .DATA_W     (32),
        .ADDR_W     (30),
        .DEPTH_LOG2 (12),
        .BANKS_LOG2 (1),
        .STARVE_MAX (2)
    ) dut (
        .clk           (clk),
        .reset_        (reset_),
        .if_spm        (if_bus),
        .mem_spm       (mem_bus),
        .dbg_stall_cnt (dbg_stall_cnt),
        .dbg_pri_if    (dbg_pri_if)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_if(input logic as_, input logic rw, input logic [29:0] addr,
                            input logic [31:0] data, input logic [3:0] be);
        if_bus.as_     = as_;
        if_bus.rw      = rw;
        if_bus.addr    = addr;
        if_bus.wr_data = data;
`ifdef SPM_BYTE_WRITE_EN
        if_bus.be      = be;
`else
        if (be === 4'bxxxx) if_bus.wr_data = data;
`endif
    endtask

    task automatic drive_mem(input logic as_, input logic rw, input logic [29:0] addr,
                             input logic [31:0] data, input logic [3:0] be);
        mem_bus.as_     = as_;
        mem_bus.rw      = rw;
        mem_bus.addr    = addr;
        mem_bus.wr_data = data;
`ifdef SPM_BYTE_WRITE_EN
        mem_bus.be      = be;
`else
        if (be === 4'bxxxx) mem_bus.wr_data = data;
`endif
    endtask

    task automatic idle_all();
        drive_if(1'b1, 1'b1, 30'h0, 32'h0, 4'h0);
        drive_mem(1'b1, 1'b1, 30'h0, 32'h0, 4'h0);
    endtask

    task automatic test_reset();
        reset_ = 1'b0;
        idle_all();
        #2;
        compared++; if (dut.if_spm.rd_valid !== 1'b0) begin mismatched++; $display("FAIL reset_if_rd_valid: got %b expected 0", if_bus.rd_valid); end
        compared++; if (mem_bus.rd_valid !== 1'b0) begin mismatched++; $display("FAIL reset_mem_rd_valid: got %b expected 0", mem_bus.rd_valid); end
        compared++; if (if_bus.rd_data !== 32'h0) begin mismatched++; $display("FAIL reset_if_rd_data: got %h expected 0", if_bus.rd_data); end
        compared++; if (mem_bus.rd_data !== 32'h0) begin mismatched++; $display("FAIL reset_mem_rd_data: got %h expected 0", mem_bus.rd_data); end
        compared++; if (dbg_stall_cnt !== 2'd0) begin mismatched++; $display("FAIL reset_stall_cnt: got %0d expected 0", dbg_stall_cnt); end
        compared++; if (dbg_pri_if !== 1'b0) begin mismatched++; $display("FAIL reset_pri_if: got %b expected 0", dbg_pri_if); end
        repeat (2) @(posedge clk);
        #3 reset_ = 1'b1;
        next_cycle();
        compared++; if (if_bus.busy !== 1'b0 || mem_bus.busy !== 1'b0) begin mismatched++; $display("FAIL release_busy: got if=%b mem=%b expected 0/0", if_bus.busy, mem_bus.busy); end
        compared++; if (if_bus.rd_valid !== 1'b0 || if_bus.rd_data !== 32'h0) begin mismatched++; $display("FAIL release_if_rd: got valid=%b data=%h expected 0/0", if_bus.rd_valid, if_bus.rd_data); end
    endtask

    task automatic test_no_conflict();
        next_cycle();
        drive_if(1'b0, 1'b1, 30'h10, 32'h0, 4'h0);
        drive_mem(1'b0, 1'b0, 30'h11, 32'hDEADBEEF, 4'hF);
        #1;
        compared++; if (if_bus.busy !== 1'b0 || mem_bus.busy !== 1'b0) begin mismatched++; $display("FAIL nc_busy: got if=%b mem=%b expected 0/0", if_bus.busy, mem_bus.busy); end
        next_cycle();
        drive_if(1'b1, 1'b1, 30'h0, 32'h0, 4'h0);
        drive_mem(1'b0, 1'b1, 30'h11, 32'h0, 4'h0);
        compared++; if (if_bus.rd_valid !== 1'b1) begin mismatched++; $display("FAIL nc_if_rd_valid: got %b expected 1", if_bus.rd_valid); end
        compared++; if (mem_bus.rd_valid !== 1'b0) begin mismatched++; $display("FAIL nc_write_no_valid: got %b expected 0", mem_bus.rd_valid); end
        #1;
        compared++; if (mem_bus.busy !== 1'b0) begin mismatched++; $display("FAIL nc_mem_busy: got %b expected 0", mem_bus.busy); end
        next_cycle();
        idle_all();
        compared++; if (mem_bus.rd_valid !== 1'b1 || mem_bus.rd_data !== 32'hDEADBEEF) begin mismatched++; $display("FAIL nc_mem_read: got valid=%b data=%h expected 1/deadbeef", mem_bus.rd_valid, mem_bus.rd_data); end
        compared++; if (if_bus.rd_valid !== 1'b0) begin mismatched++; $display("FAIL nc_if_pulse: got %b expected 0", if_bus.rd_valid); end
        next_cycle();
        compared++; if (mem_bus.rd_valid !== 1'b0 || mem_bus.rd_data !== 32'hDEADBEEF) begin mismatched++; $display("FAIL nc_mem_hold: got valid=%b data=%h expected 0/deadbeef", mem_bus.rd_valid, mem_bus.rd_data); end
    endtask

    task automatic test_conflict();
        next_cycle();
        drive_mem(1'b0, 1'b0, 30'h20, 32'h20202020, 4'hF);
        next_cycle();
        drive_mem(1'b0, 1'b0, 30'h22, 32'h22222222, 4'hF);
        next_cycle();
        drive_if(1'b0, 1'b1, 30'h20, 32'h0, 4'h0);
        drive_mem(1'b0, 1'b1, 30'h22, 32'h0, 4'h0);
        #1;
        compared++; if (if_bus.busy !== 1'b1 || mem_bus.busy !== 1'b0) begin mismatched++; $display("FAIL cf_c0_busy: got if=%b mem=%b expected 1/0", if_bus.busy, mem_bus.busy); end
        next_cycle();
        drive_mem(1'b1, 1'b1, 30'h0, 32'h0, 4'h0);
        #1;
        compared++; if (mem_bus.rd_valid !== 1'b1 || mem_bus.rd_data !== 32'h22222222) begin mismatched++; $display("FAIL cf_c1_mem_read: got valid=%b data=%h expected 1/22222222", mem_bus.rd_valid, mem_bus.rd_data); end
        compared++; if (if_bus.busy !== 1'b0) begin mismatched++; $display("FAIL cf_c1_if_busy: got %b expected 0", if_bus.busy); end
        next_cycle();
        idle_all();
        compared++; if (if_bus.rd_valid !== 1'b1 || if_bus.rd_data !== 32'h20202020) begin mismatched++; $display("FAIL cf_c2_if_read: got valid=%b data=%h expected 1/20202020", if_bus.rd_valid, if_bus.rd_data); end
        compared++; if (dbg_stall_cnt !== 2'd0) begin mismatched++; $display("FAIL cf_stall_clear: got %0d expected 0", dbg_stall_cnt); end
    endtask

    task automatic test_starvation();
        next_cycle();
        drive_if(1'b0, 1'b1, 30'h20, 32'h0, 4'h0);
        drive_mem(1'b0, 1'b1, 30'h22, 32'h0, 4'h0);
        #1;
        compared++; if (if_bus.busy !== 1'b1 || mem_bus.busy !== 1'b0) begin mismatched++; $display("FAIL sv_c0_busy: got if=%b mem=%b expected 1/0", if_bus.busy, mem_bus.busy); end
        next_cycle();
        #1;
        compared++; if (if_bus.busy !== 1'b1 || dbg_stall_cnt !== 2'd1 || dbg_pri_if !== 1'b0) begin mismatched++; $display("FAIL sv_c1: got busy=%b cnt=%0d pri=%b expected 1/1/0", if_bus.busy, dbg_stall_cnt, dbg_pri_if); end
        next_cycle();
        #1;
        compared++; if (if_bus.busy !== 1'b0 || mem_bus.busy !== 1'b1) begin mismatched++; $display("FAIL sv_c2_busy: got if=%b mem=%b expected 0/1", if_bus.busy, mem_bus.busy); end
        compared++; if (dbg_pri_if !== 1'b1 || dbg_stall_cnt !== 2'd2) begin mismatched++; $display("FAIL sv_c2_pri: got pri=%b cnt=%0d expected 1/2", dbg_pri_if, dbg_stall_cnt); end
        next_cycle();
        drive_if(1'b1, 1'b1, 30'h0, 32'h0, 4'h0);
        compared++; if (dbg_pri_if !== 1'b0 || dbg_stall_cnt !== 2'd0) begin mismatched++; $display("FAIL sv_after_pri: got pri=%b cnt=%0d expected 0/0", dbg_pri_if, dbg_stall_cnt); end
        compared++; if (if_bus.rd_valid !== 1'b1 || if_bus.rd_data !== 32'h20202020) begin mismatched++; $display("FAIL sv_if_read: got valid=%b data=%h expected 1/20202020", if_bus.rd_valid, if_bus.rd_data); end
        compared++; if (mem_bus.rd_valid !== 1'b0) begin mismatched++; $display("FAIL sv_mem_waited: got %b expected 0", mem_bus.rd_valid); end
        #1;
        compared++; if (mem_bus.busy !== 1'b0) begin mismatched++; $display("FAIL sv_mem_free: got %b expected 0", mem_bus.busy); end
        next_cycle();
        idle_all();
        compared++; if (mem_bus.rd_valid !== 1'b1 || mem_bus.rd_data !== 32'h22222222) begin mismatched++; $display("FAIL sv_mem_read: got valid=%b data=%h expected 1/22222222", mem_bus.rd_valid, mem_bus.rd_data); end
    endtask

    task automatic test_byte_write();
        logic [31:0] exp_word;
`ifdef SPM_BYTE_WRITE_EN
        exp_word = 32'h1122AA44;
`else
        exp_word = 32'hAAAAAAAA;
`endif
        next_cycle();
        drive_if(1'b0, 1'b0, 30'h40, 32'h11223344, 4'hF);
        next_cycle();
        drive_if(1'b0, 1'b0, 30'h40, 32'hAAAAAAAA, 4'b0010);
        compared++; if (if_bus.rd_valid !== 1'b0) begin mismatched++; $display("FAIL bw_write_no_valid: got %b expected 0", if_bus.rd_valid); end
        next_cycle();
        drive_if(1'b0, 1'b1, 30'h40, 32'h0, 4'h0);
        next_cycle();
        drive_if(1'b0, 1'b1, 30'h1040, 32'h0, 4'h0);
        compared++; if (if_bus.rd_valid !== 1'b1 || if_bus.rd_data !== exp_word) begin mismatched++; $display("FAIL bw_read: got valid=%b data=%h expected 1/%h", if_bus.rd_valid, if_bus.rd_data, exp_word); end
        next_cycle();
        idle_all();
        compared++; if (if_bus.rd_valid !== 1'b1 || if_bus.rd_data !== exp_word) begin mismatched++; $display("FAIL bw_alias_read: got valid=%b data=%h expected 1/%h", if_bus.rd_valid, if_bus.rd_data, exp_word); end
    endtask

    task automatic test_reset_mid_stall();
        next_cycle();
        drive_if(1'b0, 1'b1, 30'h20, 32'h0, 4'h0);
        drive_mem(1'b0, 1'b1, 30'h22, 32'h0, 4'h0);
        next_cycle();
        #2 reset_ = 1'b0;
        #1;
        compared++; if (dbg_stall_cnt !== 2'd0 || dbg_pri_if !== 1'b0) begin mismatched++; $display("FAIL rs_state: got cnt=%0d pri=%b expected 0/0", dbg_stall_cnt, dbg_pri_if); end
        compared++; if (mem_bus.rd_valid !== 1'b0 || mem_bus.rd_data !== 32'h0) begin mismatched++; $display("FAIL rs_mem_rd: got valid=%b data=%h expected 0/0", mem_bus.rd_valid, mem_bus.rd_data); end
        compared++; if (if_bus.rd_valid !== 1'b0 || if_bus.rd_data !== 32'h0) begin mismatched++; $display("FAIL rs_if_rd: got valid=%b data=%h expected 0/0", if_bus.rd_valid, if_bus.rd_data); end
        @(posedge clk);
        #3 reset_ = 1'b1;
        #1;
        compared++; if (if_bus.busy !== 1'b1 || mem_bus.busy !== 1'b0) begin mismatched++; $display("FAIL rs_release_busy: got if=%b mem=%b expected 1/0", if_bus.busy, mem_bus.busy); end
        next_cycle();
        compared++; if (dbg_stall_cnt !== 2'd1) begin mismatched++; $display("FAIL rs_count_resume: got %0d expected 1", dbg_stall_cnt); end
        idle_all();
        next_cycle();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_no_conflict();
        test_conflict();
        test_starvation();
        test_byte_write();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
